csr_reg: RTL and testbench

//  Single memory-mapped RISC-V CSR register of configurable width, addressed by a 12-bit CSR address.

---
 rtl/csr_reg_pkg.sv | 33 +++
 rtl/csr_reg_if.sv | 29 ++
 rtl/csr_reg_alu.sv | 56 +++++
 rtl/csr_reg.sv | 84 ++++++++
 tb/tb_csr_reg.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_reg_pkg.sv
// csr_reg_pkg: shared types for the CSR register slice.
//   CsrAddrT  12-bit CSR address
//   word      32-bit machine word
//   r         5-bit register index / zimm field
//   csr_op_t  Zicsr funct3 encoding (reserved codes included so every value decodes)
//   Per-peripheral CSR address constants.
package csr_reg_pkg;

  typedef logic [11:0] CsrAddrT;
  typedef logic [31:0] word;
  typedef logic [4:0]  r;

  localparam CsrAddrT CsrAddrMscratch = 12'h340;
  localparam CsrAddrT CsrAddrMtime    = 12'h701;
  localparam CsrAddrT CsrAddrMtimecmp = 12'h7C0;

  typedef enum logic [2:0] {
    CsrOpRsvd0 = 3'b000,
    CsrOpRw    = 3'b001,
    CsrOpRs    = 3'b010,
    CsrOpRc    = 3'b011,
    CsrOpRsvd4 = 3'b100,
    CsrOpRwi   = 3'b101,
    CsrOpRsi   = 3'b110,
    CsrOpRci   = 3'b111
  } csr_op_t;

  // Immediate forms take their operand from the zimm field instead of rs1.
  function automatic logic op_is_imm(csr_op_t op);
    return op inside {CsrOpRwi, CsrOpRsi, CsrOpRci};
  endfunction

endpackage

// File: rtl/csr_reg_if.sv
// csr_reg_if: CSR instruction bus between the decode/execute stage and a CSR register.
//   csr_enable  CSR instruction valid this cycle
//   csr_addr    CSR address of the instruction
//   csr_op      funct3 op
//   rs1_zimm    rs1 index / zimm field
//   rs1_data    rs1 register value
//   out         read value from the register (0 when not selected)
// master = core side, slave = CSR register side.
interface csr_reg_if;
  import csr_reg_pkg::*;

  logic    csr_enable;
  CsrAddrT csr_addr;
  csr_op_t csr_op;
  r        rs1_zimm;
  word     rs1_data;
  word     out;

  modport master (
    output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
    input  out
  );

  modport slave (
    input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
    output out
  );

endinterface

// File: rtl/csr_reg_alu.sv
// csr_reg_alu: combinational Zicsr read-modify-write datapath.
//   data          current stored value
//   op            funct3 op
//   rs1_zimm      rs1 index / zimm (also gates set/clear writes)
//   rs1_data      rs1 register value
//   new_value     value to store if write_enable
//   write_enable  op commits a write (independent of address select)
module csr_reg_alu
  import csr_reg_pkg::*;
#(
  parameter int unsigned CsrWidth = 32
) (
  input  logic [CsrWidth-1:0] data,
  input  csr_op_t             op,
  input  r                    rs1_zimm,
  input  word                 rs1_data,
  output logic [CsrWidth-1:0] new_value,
  output logic                write_enable
);

  word                 opnd_word;
  logic [CsrWidth-1:0] opnd;

  // Operand bits above CsrWidth are silently dropped.
  assign opnd_word = op_is_imm(op) ? {27'b0, rs1_zimm} : rs1_data;
  assign opnd      = opnd_word[CsrWidth-1:0];

  always_comb begin
    new_value    = data;
    write_enable = 1'b0;
    unique case (op)
      CsrOpRw, CsrOpRwi: begin
        new_value    = opnd;
        write_enable = 1'b1;
      end
      // Set/clear with a zero rs1 index or zimm is a pure read.
      CsrOpRs, CsrOpRsi: begin
        new_value    = data | opnd;
        write_enable = (rs1_zimm != 5'd0);
      end
      CsrOpRc, CsrOpRci: begin
        new_value    = data & ~opnd;
        write_enable = (rs1_zimm != 5'd0);
      end
      CsrOpRsvd0, CsrOpRsvd4: begin
        new_value    = data;
        write_enable = 1'b0;
      end
      default: begin
        new_value    = data;
        write_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_reg.sv
// csr_reg: single memory-mapped CSR register of configurable width.
//   clk               clock, rising edge
//   reset             synchronous, active-high; loads ResetValue
//   bus               CSR instruction bus (slave side)
//   ext_data          hardware side-effect write value
//   ext_write_enable  load ext_data this cycle (wins over instruction writes)
//   direct_out        stored value, zero-extended to 32 bits
// The stored register is `data`, readable hierarchically by the owning peripheral.
// Optional macro CSR_TRACE_EN: simulation-only $display of every committed write.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter int unsigned         CsrWidth   = 32,
  parameter CsrAddrT             Addr       = '0,
  parameter logic [CsrWidth-1:0] ResetValue = '0
) (
  input  logic                clk,
  input  logic                reset,
  csr_reg_if.slave            bus,
  input  logic [CsrWidth-1:0] ext_data,
  input  logic                ext_write_enable,
  output word                 direct_out
);

  logic [CsrWidth-1:0] data;
  logic [CsrWidth-1:0] data_d;
  logic [CsrWidth-1:0] alu_value;
  logic                alu_we;
  logic                sel;
  word                 data_word;

  assign sel = bus.csr_enable && (bus.csr_addr == Addr);

  csr_reg_alu #(
    .CsrWidth(CsrWidth)
  ) u_alu (
    .data        (data),
    .op          (bus.csr_op),
    .rs1_zimm    (bus.rs1_zimm),
    .rs1_data    (bus.rs1_data),
    .new_value   (alu_value),
    .write_enable(alu_we)
  );

  always_comb begin
    data_d = data;
    if (ext_write_enable) begin
      data_d = ext_data;
    end else if (sel && alu_we) begin
      data_d = alu_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= ResetValue;
    end else begin
      data <= data_d;
    end
  end

  always_comb begin
    data_word               = '0;
    data_word[CsrWidth-1:0] = data;
  end

  assign direct_out = data_word;
  // Unselected registers drive 0 so the core can OR all CSR reads together.
  assign bus.out    = sel ? data_word : '0;

`ifdef CSR_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ext_write_enable) begin
        $display("csr_reg %h ext write: old %h new %h", Addr, data, ext_data);
      end else if (sel && alu_we) begin
        $display("csr_reg %h op %s: old %h new %h", Addr, bus.csr_op.name(), data, alu_value);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_csr_reg.sv
module tb_csr_reg;
  import csr_reg_pkg::*;

  typedef struct {
    logic        en;
    logic [11:0] addr;
    logic [2:0]  op;
    logic [4:0]  zimm;
    logic [31:0] rs1;
    logic        ext_we;
    logic [31:0] ext;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_out;
    logic [31:0] exp_data;
  } vec_t;

  localparam logic [11:0] A  = CsrAddrMscratch;
  localparam logic [11:0] A1 = CsrAddrMscratch + 12'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_we;
  logic [31:0] ext32;
  logic [7:0]  ext8;
  word         direct32;
  word         direct8;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m32;
  logic [31:0] m8;

  csr_reg_if bus32 ();
  csr_reg_if bus8 ();

  csr_reg #(
    .CsrWidth  (32),
    .Addr      (CsrAddrMscratch),
    .ResetValue(32'h0)
  ) u_dut32 (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus32),
    .ext_data        (ext32),
    .ext_write_enable(ext_we),
    .direct_out      (direct32)
  );

  csr_reg #(
    .CsrWidth  (8),
    .Addr      (CsrAddrMscratch),
    .ResetValue(8'hA5)
  ) u_dut8 (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus8),
    .ext_data        (ext8),
    .ext_write_enable(ext_we),
    .direct_out      (direct8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: value after one clock, from the architectural rules.
  function automatic logic [31:0] model_next(logic [31:0] cur, int unsigned width, stim_t s);
    logic [31:0] mask;
    logic [31:0] opnd;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    if (s.ext_we) return s.ext & mask;
    if (!(s.en && s.addr == A)) return cur;
    opnd = s.op[2] ? {27'b0, s.zimm} : s.rs1;
    opnd = opnd & mask;
    case (s.op)
      3'b001, 3'b101: return opnd;
      3'b010, 3'b110: return (s.zimm == 5'd0) ? cur : (cur | opnd);
      3'b011, 3'b111: return (s.zimm == 5'd0) ? cur : (cur & ~opnd);
      default:        return cur;
    endcase
  endfunction

  function automatic logic [31:0] model_out(logic [31:0] cur, stim_t s);
    return (s.en && s.addr == A) ? cur : 32'h0;
  endfunction

  task automatic apply(input stim_t s);
    bus32.csr_enable = s.en;
    bus32.csr_addr   = s.addr;
    bus32.csr_op     = csr_op_t'(s.op);
    bus32.rs1_zimm   = s.zimm;
    bus32.rs1_data   = s.rs1;
    bus8.csr_enable  = s.en;
    bus8.csr_addr    = s.addr;
    bus8.csr_op      = csr_op_t'(s.op);
    bus8.rs1_zimm    = s.zimm;
    bus8.rs1_data    = s.rs1;
    ext_we           = s.ext_we;
    ext32            = s.ext;
    ext8             = s.ext[7:0];
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input stim_t s, input string tag);
    logic [31:0] n32;
    logic [31:0] n8;
    apply(s);
    #1;
    check({tag, " out32"}, bus32.out, model_out(m32, s));
    check({tag, " out8"}, bus8.out, model_out(m8, s));
    n32 = model_next(m32, 32, s);
    n8  = model_next(m8, 8, s);
    @(posedge clk);
    #1;
    m32 = n32;
    m8  = n8;
    check({tag, " direct32"}, direct32, m32);
    check({tag, " direct8"}, direct8, m8);
    @(negedge clk);
  endtask

  function automatic stim_t mk(logic en, logic [11:0] addr, logic [2:0] op, logic [4:0] zimm,
                               logic [31:0] rs1, logic xwe, logic [31:0] x);
    stim_t s;
    s.en = en; s.addr = addr; s.op = op; s.zimm = zimm; s.rs1 = rs1; s.ext_we = xwe; s.ext = x;
    return s;
  endfunction

  vec_t  tbl[15];
  stim_t idle;
  stim_t rs;

  initial begin
    idle = mk(1'b0, A, 3'b000, 5'd0, 32'h0, 1'b0, 32'h0);

    // Directed sequence for the 32-bit instance, starting from reset value 0.
    tbl[0]  = '{mk(1, A,  3'b001, 5'd1, 32'h1234_5678, 0, 0), 32'h0,         32'h1234_5678};
    tbl[1]  = '{mk(1, A,  3'b001, 5'd1, 32'h0000_000F, 0, 0), 32'h1234_5678, 32'h0F};
    tbl[2]  = '{mk(1, A,  3'b010, 5'd5, 32'h0000_00F0, 0, 0), 32'h0F,        32'hFF};
    tbl[3]  = '{mk(1, A,  3'b011, 5'd5, 32'h0000_000F, 0, 0), 32'hFF,        32'hF0};
    tbl[4]  = '{mk(1, A,  3'b010, 5'd0, 32'h0000_FFFF, 0, 0), 32'hF0,        32'hF0};
    tbl[5]  = '{mk(1, A,  3'b101, 5'd31, 32'hFFFF_FFFF, 0, 0), 32'hF0,       32'h1F};
    tbl[6]  = '{mk(1, A,  3'b111, 5'd1, 32'hFFFF_FFFF, 0, 0), 32'h1F,        32'h1E};
    tbl[7]  = '{mk(1, A,  3'b110, 5'd0, 32'hFFFF_FFFF, 0, 0), 32'h1E,        32'h1E};
    tbl[8]  = '{mk(1, A1, 3'b001, 5'd1, 32'h0000_DEAD, 0, 0), 32'h0,         32'h1E};
    tbl[9]  = '{mk(0, A,  3'b001, 5'd1, 32'h0000_DEAD, 0, 0), 32'h0,         32'h1E};
    tbl[10] = '{mk(1, A,  3'b000, 5'd3, 32'h0000_FFFF, 0, 0), 32'h1E,        32'h1E};
    tbl[11] = '{mk(1, A,  3'b100, 5'd7, 32'h0000_FFFF, 0, 0), 32'h1E,        32'h1E};
    tbl[12] = '{mk(1, A,  3'b001, 5'd1, 32'h0000_0007, 1, 32'h3), 32'h1E,    32'h3};
    tbl[13] = '{mk(0, A,  3'b000, 5'd0, 32'h0,         1, 32'h55AA), 32'h0,  32'h55AA};
    tbl[14] = '{mk(1, A,  3'b011, 5'd5, 32'hFFFF_00AA, 0, 0), 32'h55AA,      32'h5500};

    reset = 1'b1;
    apply(idle);
    @(posedge clk);
    #1;
    m32 = 32'h0;
    m8  = 32'hA5;
    check("reset direct8", direct8, 32'hA5);
    check("reset direct32", direct32, 32'h0);
    check("reset out8", bus8.out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].s);
      #1;
      check($sformatf("row%0d out", i), bus32.out, tbl[i].exp_out);
      step(tbl[i].s, $sformatf("row%0d", i));
      check($sformatf("row%0d data", i), direct32, tbl[i].exp_data);
    end

    // Narrow instance drops operand bits above its width.
    step(mk(1, A, 3'b001, 5'd1, 32'h1234_5678, 0, 0), "narrow rw");
    check("narrow direct8", direct8, 32'h78);

    // Reset beats a simultaneous ext write and instruction write.
    reset = 1'b1;
    apply(mk(1, A, 3'b001, 5'd1, 32'hCAFE_F00D, 1, 32'h1111_1111));
    @(posedge clk);
    #1;
    check("midreset direct32", direct32, 32'h0);
    check("midreset direct8", direct8, 32'hA5);
    m32 = 32'h0;
    m8  = 32'hA5;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rs.en     = ($urandom_range(0, 3) != 0);
      rs.addr   = ($urandom_range(0, 3) == 0) ? A1 : A;
      rs.op     = 3'($urandom_range(0, 7));
      rs.zimm   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs.rs1    = $urandom;
      rs.ext_we = ($urandom_range(0, 7) == 0);
      rs.ext    = $urandom;
      step(rs, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
